counter_ctrl: RTL and testbench

Sequencer for the lab's free-running binary counters: adds start/stop/pause control, a programmable prescaler, a programmable terminal value and one-shot or auto-reload modes. It sits between push-button/switch logic and the display path.
- Its `count` output replaces a raw counter's output.
- Its `done`/`wrap` pulses drive downstream events such as LED blink or digit advance.

---
 rtl/counter_ctrl_if.sv | 41 ++++
 rtl/counter_ctrl.sv | 124 ++++++++++++
 tb/tb_counter_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: control/status bundle between button logic and counter_ctrl.
// Ports: start/stop/pause/limit/prescale/auto_reload (+dir with COUNTER_CTRL_DOWN_EN) in,
//        count/busy/done/wrap out (as seen from the counter).
interface counter_ctrl_if #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
);
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [WIDTH-1:0]      limit;
    logic [PRESCALE_W-1:0] prescale;
    logic                  auto_reload;
`ifdef COUNTER_CTRL_DOWN_EN
    logic                  dir;
`endif
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;
    logic                  wrap;

`ifdef COUNTER_CTRL_DOWN_EN
    modport master (
        output start, stop, pause, limit, prescale, auto_reload, dir,
        input  count, busy, done, wrap
    );
    modport slave (
        input  start, stop, pause, limit, prescale, auto_reload, dir,
        output count, busy, done, wrap
    );
`else
    modport master (
        output start, stop, pause, limit, prescale, auto_reload,
        input  count, busy, done, wrap
    );
    modport slave (
        input  start, stop, pause, limit, prescale, auto_reload,
        output count, busy, done, wrap
    );
`endif
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/pause sequencer with prescaler, terminal value and
// one-shot/auto-reload modes. Ports: clk, rst (sync, active high), bus (slave).
// Optional COUNTER_CTRL_DOWN_EN adds bus.dir for down-counting.
module counter_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input logic           clk,
    input logic           rst,
    counter_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam logic [WIDTH-1:0]      ONE_W = 1;
    localparam logic [PRESCALE_W-1:0] ONE_P = 1;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]      lim_q, lim_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;

    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      step_val;
    logic [WIDTH-1:0]      reload_val;
    logic                  at_end;

`ifdef COUNTER_CTRL_DOWN_EN
    logic dir_q, dir_d;

    assign load_val   = bus.dir ? bus.limit : '0;
    assign at_end     = dir_q ? (count_q == '0) : (count_q == lim_q);
    assign step_val   = dir_q ? (count_q - ONE_W) : (count_q + ONE_W);
    assign reload_val = dir_q ? lim_q : '0;
`else
    assign load_val   = '0;
    assign at_end     = (count_q == lim_q);
    assign step_val   = count_q + ONE_W;
    assign reload_val = '0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        lim_d   = lim_q;
        psc_d   = psc_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
`ifdef COUNTER_CTRL_DOWN_EN
        dir_d   = dir_q;
`endif
        if (bus.stop) begin
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else if (bus.start) begin
            state_d = RUN;
            lim_d   = bus.limit;
            psc_d   = bus.prescale;
            pre_d   = '0;
            count_d = load_val;
`ifdef COUNTER_CTRL_DOWN_EN
            dir_d   = bus.dir;
`endif
        end else if (state_q != IDLE) begin
            if (bus.pause) begin
                state_d = PAUSE;
            end else begin
                // A cycle leaving PAUSE already advances the prescaler.
                state_d = RUN;
                if (pre_q == psc_q) begin
                    pre_d = '0;
                    if (!at_end) begin
                        count_d = step_val;
                    end else if (bus.auto_reload) begin
                        count_d = reload_val;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + ONE_P;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            lim_q   <= '0;
            psc_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef COUNTER_CTRL_DOWN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            lim_q   <= lim_d;
            psc_q   <= psc_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
`ifdef COUNTER_CTRL_DOWN_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed + randomized bench for counter_ctrl, checked every
// cycle against an elapsed-time model of the counter.
module tb_counter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    counter_ctrl_if #(.WIDTH(4), .PRESCALE_W(8)) bus_if ();

    counter_ctrl #(.WIDTH(4), .PRESCALE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: active (non-paused) cycles since start decide everything.
    bit m_busy = 0;
    bit m_done = 0;
    bit m_wrap = 0;
    bit m_ar   = 0;
    int m_count = 0;
    int m_el   = 0;
    int m_lim  = 0;
    int m_p    = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    always @(posedge clk) begin
        m_done = 0;
        m_wrap = 0;
        if (rst) begin
            m_busy = 0; m_count = 0; m_el = 0; m_lim = 0; m_p = 0;
        end else if (bus_if.stop) begin
            m_busy = 0; m_count = 0; m_el = 0;
        end else if (bus_if.start) begin
            m_busy = 1; m_count = 0; m_el = 0;
            m_lim = int'(bus_if.limit);
            m_p = int'(bus_if.prescale);
            m_ar = bus_if.auto_reload;
        end else if (m_busy && !bus_if.pause) begin
            m_el++;
            if (m_el % (m_p + 1) == 0) begin
                int t;
                t = m_el / (m_p + 1);
                if (m_ar) begin
                    m_count = t % (m_lim + 1);
                    m_wrap = (m_count == 0);
                end else if (t == m_lim + 1) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_count = t;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_count", 32'(bus_if.count), 32'(m_count));
            chk("model_busy", 32'(bus_if.busy), 32'(m_busy));
            chk("model_done", 32'(bus_if.done), 32'(m_done));
            chk("model_wrap", 32'(bus_if.wrap), 32'(m_wrap));
            if (bus_if.done === 1'b1 && bus_if.wrap === 1'b1)
                chk("done_wrap_excl", 32'd1, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
    endtask

    task automatic go(input int lim, input int p, input bit ar);
        bus_if.limit       = 4'(lim);
        bus_if.prescale    = 8'(p);
        bus_if.auto_reload = ar;
        bus_if.start       = 1'b1;
        step();
    endtask

    initial begin
        int exp_os[8];
        int exp_ar[7];
        int n;
        exp_os = '{0, 0, 1, 1, 2, 2, 3, 3};
        exp_ar = '{0, 1, 2, 0, 1, 2, 0};

        bus_if.start = 0; bus_if.stop = 0; bus_if.pause = 0;
        bus_if.limit = 0; bus_if.prescale = 0; bus_if.auto_reload = 0;
`ifdef COUNTER_CTRL_DOWN_EN
        bus_if.dir = 0;
`endif
        rst = 1;
        step(); step();
        chk("rst_count", 32'(bus_if.count), 0);
        chk("rst_busy", 32'(bus_if.busy), 0);
        rst = 0;
        chk_en = 1;
        step();

        // One-shot limit=3 P=1
        go(3, 1, 0);
        n = 0;
        while (bus_if.busy && n < 50) begin
            if (n < 8) chk($sformatf("os_seq%0d", n), 32'(bus_if.count),
                           32'(exp_os[n]));
            n++;
            step();
        end
        chk("os_busy_len", 32'(n), 8);
        chk("os_done", 32'(bus_if.done), 1);
        chk("os_hold", 32'(bus_if.count), 3);
        step();
        chk("os_done_clr", 32'(bus_if.done), 0);
        chk("os_hold2", 32'(bus_if.count), 3);

        // Reset mid-run at count 5
        go(15, 0, 0);
        repeat (5) step();
        chk("mid_count5", 32'(bus_if.count), 5);
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_count", 32'(bus_if.count), 0);
        chk("mid_rst_busy", 32'(bus_if.busy), 0);
        chk("mid_rst_done", 32'(bus_if.done), 0);
        chk("mid_rst_wrap", 32'(bus_if.wrap), 0);

        // Auto-reload limit=2 P=0
        go(2, 0, 1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("ar_seq%0d", i), 32'(bus_if.count),
                32'(exp_ar[i]));
            chk($sformatf("ar_wrap%0d", i), 32'(bus_if.wrap),
                32'((i == 3 || i == 6) ? 1 : 0));
            step();
        end
        bus_if.stop = 1;
        step();
        chk("stop_count", 32'(bus_if.count), 0);

        // limit=0 P=0 one-shot
        go(0, 0, 0);
        chk("l0_busy", 32'(bus_if.busy), 1);
        step();
        chk("l0_busy_end", 32'(bus_if.busy), 0);
        chk("l0_done", 32'(bus_if.done), 1);

        // Pause at count=4, prescaler=2
        go(15, 3, 0);
        repeat (18) step();
        chk("pz_pre", 32'(bus_if.count), 4);
        bus_if.pause = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pz_hold", 32'(bus_if.count), 4);
        end
        bus_if.pause = 0;
        step();
        chk("pz_exit", 32'(bus_if.count), 4);
        step();
        chk("pz_tick", 32'(bus_if.count), 5);

        // Restart at count 7 with limit=1, P=1
        go(15, 1, 0);
        repeat (14) step();
        chk("rs_count7", 32'(bus_if.count), 7);
        go(1, 1, 0);
        chk("rs_count0", 32'(bus_if.count), 0);
        n = 0;
        while (bus_if.busy && n < 100) begin
            n++;
            step();
        end
        chk("rs_len", 32'(n), 4);
        chk("rs_done", 32'(bus_if.done), 1);

        // start+stop together while running
        go(9, 0, 1);
        repeat (3) step();
        bus_if.start = 1;
        bus_if.stop  = 1;
        step();
        chk("ss_busy", 32'(bus_if.busy), 0);
        chk("ss_count", 32'(bus_if.count), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus_if.limit    = 4'($urandom);
            bus_if.prescale = 8'($urandom_range(0, 3));
            bus_if.start    = ($urandom_range(0, 39) == 0);
            bus_if.stop     = ($urandom_range(0, 79) == 0);
            if (bus_if.start) bus_if.auto_reload = 1'($urandom);
            if ($urandom_range(0, 7) == 0) bus_if.pause = ~bus_if.pause;
            rst = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            #1;
        end
        rst = 0;
        bus_if.start = 0;
        bus_if.stop = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
